// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin front end that shares one pipelined CORDIC
// rotator among NREQ requesters. Winning operands are registered into the
// rotator, a {valid, id} tag rides alongside the rotator latency, and each
// result is returned to its owner. Per-requester counters cap in-flight jobs.
module cordic_arbiter #(
    parameter int NREQ    = 4,
    parameter int XY_SZ   = 16,
    parameter int LATENCY = 16,
    parameter int MAX_OUT = 4,
    parameter int IDW     = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [32*NREQ-1:0]    req_angle,
    input  logic [XY_SZ*NREQ-1:0] req_xin,
    input  logic [XY_SZ*NREQ-1:0] req_yin,
    output logic [31:0]           cordic_angle,
    output logic [XY_SZ-1:0]      cordic_xin,
    output logic [XY_SZ-1:0]      cordic_yin,
    input  logic [XY_SZ:0]        cordic_xout,
    input  logic [XY_SZ:0]        cordic_yout,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [XY_SZ:0]        rsp_x,
    output logic [XY_SZ:0]        rsp_y,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_OUT + 1);

    // Arbitration / issue state
    logic [IDW-1:0]   r_ptr;
    logic [31:0]      r_angle;
    logic [XY_SZ-1:0] r_xin;
    logic [XY_SZ-1:0] r_yin;

    // Tag pipe: element k is visible k+1 cycles after the accept
    logic [LATENCY:0] r_tag_vld;
    logic [IDW-1:0]   r_tag_id [0:LATENCY];

    // Response registers and per-requester in-flight counters
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [XY_SZ:0]   r_rsp_x;
    logic [XY_SZ:0]   r_rsp_y;
    logic [CW-1:0]    r_out_cnt [NREQ];

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_inc;
    logic [NREQ-1:0]  w_dec;
    logic             w_accept;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [31:0]      w_angle;
    logic [XY_SZ-1:0] w_xin;
    logic [XY_SZ-1:0] w_yin;
    logic             w_busy;

    // Eligibility: a response leaving this cycle frees its slot immediately,
    // so a capped requester can be re-accepted in the very cycle it drains.
    always_comb begin
        w_elig = '0;
        w_dec  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_dec[i]  = r_rsp_valid && (r_rsp_id == IDW'(i));
            w_elig[i] = req_valid[i] && ((r_out_cnt[i] < CW'(MAX_OUT)) || w_dec[i]);
        end
    end

    // Round-robin search from the pointer, then mux the winner's operands
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the loops can leave a value unassigned and infer a latch.
        w_accept = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        w_angle  = '0;
        w_xin    = '0;
        w_yin    = '0;
        w_inc    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_accept && w_elig[w_idx]) begin
                w_accept = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_accept && (w_gnt_id == IDW'(i))) begin
                w_inc[i] = 1'b1;
                w_angle  = req_angle[32*i +: 32];
                w_xin    = req_xin[XY_SZ*i +: XY_SZ];
                w_yin    = req_yin[XY_SZ*i +: XY_SZ];
            end
        end
        w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        req_ready = w_accept ? (NREQ'(1) << w_gnt_id) : '0;
    end

    // Issue registers and pointer; idle cycles present zero operands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_angle <= '0;
            r_xin   <= '0;
            r_yin   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling
            // pre-edge values, independent of statement order.
            r_angle <= w_angle;
            r_xin   <= w_xin;
            r_yin   <= w_yin;
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Tag pipe advances every cycle, aligned with the rotator latency
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the id array is cleared too, so stale ids never reach
            // rsp_id after a reset; the array is small, so this is cheap.
            r_tag_vld <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[LATENCY-1:0], w_accept};
            r_tag_id[0] <= w_accept ? w_gnt_id : '0;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Response capture: data loads only for a valid tag and holds otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_x     <= '0;
            r_rsp_y     <= '0;
        end else begin
            r_rsp_valid <= r_tag_vld[LATENCY];
            r_rsp_id    <= r_tag_id[LATENCY];
            if (r_tag_vld[LATENCY]) begin
                r_rsp_x <= cordic_xout;
                r_rsp_y <= cordic_yout;
            end
        end
    end

    // Outstanding counters: +1 on accept, -1 on returned response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_out_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
                    2'b01:   r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
                    default: r_out_cnt[i] <= r_out_cnt[i];
                endcase
            end
        end
    end

    // Busy while any requester has a job in flight
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_busy = w_busy | (r_out_cnt[i] != '0);
        end
    end

    assign cordic_angle = r_angle;
    assign cordic_xin   = r_xin;
    assign cordic_yin   = r_yin;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_x        = r_rsp_x;
    assign rsp_y        = r_rsp_y;
    assign busy         = w_busy;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: random and directed stimulus against a queue-based
// reference model of the arbiter, with a stand-in rotator of fixed latency.
module tb_cordic_arbiter;

    localparam int NREQ    = 4;
    localparam int XY_SZ   = 16;
    localparam int LATENCY = 16;
    localparam int MAX_OUT = 4;
    localparam int IDW     = 2;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [32*NREQ-1:0]    req_angle;
    logic [XY_SZ*NREQ-1:0] req_xin;
    logic [XY_SZ*NREQ-1:0] req_yin;
    logic [31:0]           cordic_angle;
    logic [XY_SZ-1:0]      cordic_xin;
    logic [XY_SZ-1:0]      cordic_yin;
    logic [XY_SZ:0]        cordic_xout;
    logic [XY_SZ:0]        cordic_yout;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [XY_SZ:0]        rsp_x;
    logic [XY_SZ:0]        rsp_y;
    logic                  busy;

    always #5 clock = ~clock;

    cordic_arbiter #(
        .NREQ(NREQ), .XY_SZ(XY_SZ), .LATENCY(LATENCY), .MAX_OUT(MAX_OUT), .IDW(IDW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_xin(req_xin), .req_yin(req_yin),
        .cordic_angle(cordic_angle), .cordic_xin(cordic_xin), .cordic_yin(cordic_yin),
        .cordic_xout(cordic_xout), .cordic_yout(cordic_yout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .busy(busy)
    );

    // Stand-in rotator: any bit-mixing function works, the arbiter only routes
    function automatic logic [XY_SZ:0] rot_x(input logic [31:0] a, input logic [XY_SZ-1:0] x);
        return {x[XY_SZ-1], x} + a[XY_SZ:0];
    endfunction

    function automatic logic [XY_SZ:0] rot_y(input logic [31:0] a, input logic [XY_SZ-1:0] y);
        return {y[XY_SZ-1], y} ^ a[31 -: XY_SZ+1];
    endfunction

    logic [XY_SZ:0] rx_pipe [LATENCY];
    logic [XY_SZ:0] ry_pipe [LATENCY];

    // Rotator model: inputs sampled on an edge appear LATENCY-1 cycles later
    always @(posedge clock) begin
        rx_pipe[0] <= rot_x(cordic_angle, cordic_xin);
        ry_pipe[0] <= rot_y(cordic_angle, cordic_yin);
        for (int i = 1; i < LATENCY; i++) begin
            rx_pipe[i] <= rx_pipe[i-1];
            ry_pipe[i] <= ry_pipe[i-1];
        end
    end
    assign cordic_xout = rx_pipe[LATENCY-1];
    assign cordic_yout = ry_pipe[LATENCY-1];

    // Reference model state
    typedef struct {
        int             due;
        int             id;
        logic [XY_SZ:0] x;
        logic [XY_SZ:0] y;
    } rsp_t;

    rsp_t             exp_q [$];
    int               m_cnt [NREQ];
    int               m_ptr;
    int               cyc;
    logic [31:0]      exp_ang;
    logic [XY_SZ-1:0] exp_xin;
    logic [XY_SZ-1:0] exp_yin;
    logic [XY_SZ:0]   m_rsp_x;
    logic [XY_SZ:0]   m_rsp_y;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr   = 0;
        cyc     = 0;
        exp_ang = '0;
        exp_xin = '0;
        exp_yin = '0;
        m_rsp_x = '0;
        m_rsp_y = '0;
    endtask

    // One clock cycle: drive after the edge, compare and advance the model mid-cycle
    task automatic do_cycle(input logic [NREQ-1:0] v, input bit fixed);
        int   dec;
        int   gnt;
        int   idx;
        int   eff;
        logic exp_rv;
        logic exp_busy;
        logic [NREQ-1:0] exp_ready;
        rsp_t r;
        @(posedge clock);
        #1;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_angle[32*i +: 32]       = $urandom;
            req_xin[XY_SZ*i +: XY_SZ]   = XY_SZ'($urandom);
            req_yin[XY_SZ*i +: XY_SZ]   = XY_SZ'($urandom);
        end
        if (fixed) begin
            req_angle[64 +: 32]        = 32'h2000_0000;
            req_xin[2*XY_SZ +: XY_SZ]  = XY_SZ'(1000);
            req_yin[2*XY_SZ +: XY_SZ]  = '0;
        end
        @(negedge clock);

        exp_rv = 1'b0;
        dec    = -1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r       = exp_q.pop_front();
            exp_rv  = 1'b1;
            dec     = r.id;
            m_rsp_x = r.x;
            m_rsp_y = r.y;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) check("rsp_id", 64'(rsp_id), 64'(dec));
        check("rsp_x", 64'(rsp_x), 64'(m_rsp_x));
        check("rsp_y", 64'(rsp_y), 64'(m_rsp_y));

        exp_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_busy = exp_busy | (m_cnt[i] != 0);
        check("busy", 64'(busy), 64'(exp_busy));

        check("cordic_angle", 64'(cordic_angle), 64'(exp_ang));
        check("cordic_xin", 64'(cordic_xin), 64'(exp_xin));
        check("cordic_yin", 64'(cordic_yin), 64'(exp_yin));

        gnt = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            eff = m_cnt[idx] - ((dec == idx) ? 1 : 0);
            if (gnt < 0 && v[idx] && eff < MAX_OUT) gnt = idx;
        end
        exp_ready = (gnt >= 0) ? NREQ'(1 << gnt) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));

        if (dec >= 0) m_cnt[dec]--;
        if (gnt >= 0) begin
            m_cnt[gnt]++;
            m_ptr   = (gnt + 1) % NREQ;
            exp_ang = req_angle[32*gnt +: 32];
            exp_xin = req_xin[XY_SZ*gnt +: XY_SZ];
            exp_yin = req_yin[XY_SZ*gnt +: XY_SZ];
            r.due   = cyc + LATENCY + 2;
            r.id    = gnt;
            r.x     = rot_x(exp_ang, exp_xin);
            r.y     = rot_y(exp_ang, exp_yin);
            exp_q.push_back(r);
        end else begin
            exp_ang = '0;
            exp_xin = '0;
            exp_yin = '0;
        end
        cyc++;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any edge
    task automatic pulse_reset();
        req_valid = '0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_cordic_angle", 64'(cordic_angle), 64'd0);
        check("rst_cordic_xin", 64'(cordic_xin), 64'd0);
        check("rst_cordic_yin", 64'(cordic_yin), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_x", 64'(rsp_x), 64'd0);
        check("rst_rsp_y", 64'(rsp_y), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_angle = '0;
        req_xin   = '0;
        req_yin   = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("por_busy", 64'(busy), 64'd0);
        check("por_rsp_valid", 64'(rsp_valid), 64'd0);
        check("por_cordic_angle", 64'(cordic_angle), 64'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;

        // Single job from requester 2, then drain past its response
        do_cycle(4'b0100, 1'b1);
        repeat (LATENCY + 6) do_cycle('0, 1'b0);

        // All requesters valid: strict rotation, cap reached per requester
        repeat (40) do_cycle('1, 1'b0);
        repeat (LATENCY + 4) do_cycle('0, 1'b0);

        // One requester held high: cap and same-cycle re-accept
        repeat (40) do_cycle(4'b0010, 1'b0);
        repeat (LATENCY + 4) do_cycle('0, 1'b0);

        // Pointer wrap: requesters 0 and 3, then only requester 0
        repeat (3) do_cycle(4'b1000, 1'b0);
        repeat (4) do_cycle(4'b1001, 1'b0);
        repeat (3) do_cycle(4'b0001, 1'b0);
        repeat (LATENCY + 4) do_cycle('0, 1'b0);

        // Random traffic, sparse then dense
        repeat (300) do_cycle(NREQ'($urandom & $urandom), 1'b0);
        repeat (300) do_cycle(NREQ'($urandom | $urandom), 1'b0);
        repeat (LATENCY + 4) do_cycle('0, 1'b0);

        // Reset with five jobs in flight; nothing may come back afterwards
        repeat (5) do_cycle('1, 1'b0);
        pulse_reset();
        repeat (30) do_cycle('0, 1'b0);

        // Long idle stretch
        repeat (40) do_cycle('0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
